// File: rtl/data_pair_packer_pkg.sv
// ----------------------------------------------------------------------------
// data_pair_packer_pkg
// Shared constants and types for the 128-bit to 64-bit pair packer.
//   DIN_WIDTH        input beat width
//   DOUT_WIDTH       output word width
//   ENTRY_WIDTH      width of one stored entry (two input beats)
//   WORDS_PER_ENTRY  output words per stored entry
//   entry_t          one stored entry, first beat in the upper half
//   phase_e          pairing phase (waiting for first / second beat)
// ----------------------------------------------------------------------------
package data_pair_packer_pkg;

    localparam int unsigned DIN_WIDTH       = 128;
    localparam int unsigned DOUT_WIDTH      = 64;
    localparam int unsigned ENTRY_WIDTH     = 2 * DIN_WIDTH;
    localparam int unsigned WORDS_PER_ENTRY = ENTRY_WIDTH / DOUT_WIDTH;
    localparam int unsigned DEFAULT_DEPTH   = 16;

    typedef logic [ENTRY_WIDTH-1:0] entry_t;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_e;

    // First beat goes to the upper half so word 0 is the first beat's MS word.
    function automatic entry_t make_entry(input logic [DIN_WIDTH-1:0] a,
                                          input logic [DIN_WIDTH-1:0] b);
        return {a, b};
    endfunction

endpackage

// File: rtl/data_pair_packer_fifo.sv
// ----------------------------------------------------------------------------
// wide_sync_fifo
// Single-clock FIFO of wide entries, read out first-word-fall-through as a
// sequence of narrower words, most-significant word first.
//   clk_i      clock
//   rst_i      asynchronous active-high reset (pointers, count, word index)
//   wr_en_i    push wr_data_i (ignored while full)
//   wr_data_i  entry to store
//   rd_en_i    downstream accepts rd_data_o (ignored while empty)
//   rd_data_o  current word of the head entry, zero when empty
//   valid_o    FIFO holds at least one entry
//   full_o     FIFO holds DEPTH entries
//   empty_o    FIFO holds no entries
// ----------------------------------------------------------------------------
module wide_sync_fifo #(
    parameter int unsigned ENTRY_WIDTH = 256,
    parameter int unsigned DOUT_WIDTH  = 64,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [ENTRY_WIDTH-1:0] wr_data_i,
    input  logic                   rd_en_i,
    output logic [DOUT_WIDTH-1:0]  rd_data_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned WORDS  = ENTRY_WIDTH / DOUT_WIDTH;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WIDX_W = $clog2(WORDS);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS - 1);

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [WIDX_W-1:0] widx_q,   widx_d;

    logic push, xfer, pop;

    logic [ENTRY_WIDTH-1:0] head;
    logic [DOUT_WIDTH-1:0]  words [WORDS];

    assign valid_o = (count_q != '0);
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);

    assign push = wr_en_i && !full_o;
    assign xfer = valid_o && rd_en_i;
    // The head entry leaves only once its last word has been taken.
    assign pop  = xfer && (widx_q == WIDX_LAST);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        widx_d   = widx_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (xfer) begin
            widx_d = pop ? '0 : widx_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            widx_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            widx_q   <= widx_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        for (int unsigned k = 0; k < WORDS; k++) begin
            words[k] = head[ENTRY_WIDTH-1-k*DOUT_WIDTH -: DOUT_WIDTH];
        end
    end

    assign rd_data_o = valid_o ? words[widx_q] : '0;

endmodule

// File: rtl/data_pair_packer.sv
// ----------------------------------------------------------------------------
// data_pair_packer
// Pairs consecutive accepted input beats into one wide entry, queues entries
// in a FIFO and emits each entry as four output words, first beat MS word
// first.
//   CLK      clock
//   RST      asynchronous active-high reset
//   iVALID   input beat valid
//   oREADY   an input beat can be accepted this cycle
//   DIN      input beat
//   oVALID   DOUT holds a valid word
//   iREADY   downstream accepts DOUT
//   DOUT     output word
//   FULL     FIFO holds DEPTH entries
//   EMPTY    FIFO holds no entries
//   PENDING  a first beat is held waiting for its partner
// ----------------------------------------------------------------------------
module data_pair_packer #(
    parameter int unsigned DIN_WIDTH  = data_pair_packer_pkg::DIN_WIDTH,
    parameter int unsigned DOUT_WIDTH = data_pair_packer_pkg::DOUT_WIDTH,
    parameter int unsigned DEPTH      = data_pair_packer_pkg::DEFAULT_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iVALID,
    output logic                  oREADY,
    input  logic [DIN_WIDTH-1:0]  DIN,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic [DOUT_WIDTH-1:0] DOUT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  PENDING
);

    import data_pair_packer_pkg::*;

    phase_e                 phase_q, phase_d;
    logic [DIN_WIDTH-1:0]   hold_q,  hold_d;
    logic                   accept;
    logic                   push;
    logic [2*DIN_WIDTH-1:0] entry;

    // Only registered occupancy gates input; no path from iREADY.
    assign oREADY  = !RST && !FULL;
    assign accept  = iVALID && oREADY;
    assign PENDING = (phase_q == PH_SECOND);

    // First beat in the upper half gives word order A.hi, A.lo, B.hi, B.lo.
    assign entry = {hold_q, DIN};

    always_comb begin
        phase_d = phase_q;
        hold_d  = hold_q;
        push    = 1'b0;
        if (accept) begin
            if (phase_q == PH_FIRST) begin
                hold_d  = DIN;
                phase_d = PH_SECOND;
            end else begin
                push    = 1'b1;
                phase_d = PH_FIRST;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= PH_FIRST;
            hold_q  <= '0;
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
        end
    end

    wide_sync_fifo #(
        .ENTRY_WIDTH (2 * DIN_WIDTH),
        .DOUT_WIDTH  (DOUT_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RST),
        .wr_en_i   (push),
        .wr_data_i (entry),
        .rd_en_i   (iREADY),
        .rd_data_o (DOUT),
        .valid_o   (oVALID),
        .full_o    (FULL),
        .empty_o   (EMPTY)
    );

endmodule

// File: tb/tb_data_pair_packer.sv
// ----------------------------------------------------------------------------
// tb_data_pair_packer
// Directed vector table plus hand sequences for reset, full and concurrency,
// with a negedge reference model of the expected word stream.
// ----------------------------------------------------------------------------
module tb_data_pair_packer;

    import data_pair_packer_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         iVALID;
    logic         oREADY;
    logic [127:0] DIN;
    logic         oVALID;
    logic         iREADY;
    logic [63:0]  DOUT;
    logic         FULL;
    logic         EMPTY;
    logic         PENDING;

    always #5 CLK = ~CLK;

    data_pair_packer #(
        .DIN_WIDTH  (128),
        .DOUT_WIDTH (64),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iVALID  (iVALID),
        .oREADY  (oREADY),
        .DIN     (DIN),
        .oVALID  (oVALID),
        .iREADY  (iREADY),
        .DOUT    (DOUT),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .PENDING (PENDING)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] hi(input logic [127:0] x);
        return x[127:64];
    endfunction

    function automatic logic [63:0] lo(input logic [127:0] x);
        return x[63:0];
    endfunction

    function automatic logic [127:0] beat(input int unsigned i);
        return {32'(32'hAAAA_0000 + i), 32'h0000_0001, 32'(32'hBBBB_0000 + i), 32'h0000_0002};
    endfunction

    // ------------------------------------------------------------------
    // Reference model, sampled on the falling edge where every input and
    // registered output is stable for the coming rising edge.
    // ------------------------------------------------------------------
    logic [63:0]  exp_q [$];
    logic         m_phase   = 1'b0;
    logic [127:0] m_hold    = '0;
    int unsigned  words_in  = 0;
    int unsigned  words_out = 0;

    always @(negedge CLK) begin
        int unsigned ent;
        entry_t      e;
        if (RST) begin
            exp_q.delete();
            m_phase = 1'b0;
        end else begin
            ent = (exp_q.size() + 3) / 4;
            chk1("mon_ovalid",  oVALID,  exp_q.size() != 0);
            chk1("mon_oready",  oREADY,  ent < DEPTH);
            chk1("mon_full",    FULL,    ent == DEPTH);
            chk1("mon_empty",   EMPTY,   ent == 0);
            chk1("mon_pending", PENDING, m_phase);
            if (oVALID && iREADY) begin
                if (exp_q.size() == 0) begin
                    chk1("mon_unexpected_word", 1'b1, 1'b0);
                end else begin
                    chk("mon_dout", DOUT, exp_q[0]);
                    void'(exp_q.pop_front());
                    words_out++;
                end
            end
            if (iVALID && oREADY) begin
                if (!m_phase) begin
                    m_hold  = DIN;
                    m_phase = 1'b1;
                end else begin
                    e = make_entry(m_hold, DIN);
                    exp_q.push_back(e[255:192]);
                    exp_q.push_back(e[191:128]);
                    exp_q.push_back(e[127:64]);
                    exp_q.push_back(e[63:0]);
                    words_in += 4;
                    m_phase = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic         valid;
        logic [127:0] din;
        logic         rdy;
        logic         e_oready;
        logic         e_ovalid;
        logic [63:0]  e_dout;
        logic         e_pending;
        logic         e_empty;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [127:0] d, input logic r,
                                input logic eor, input logic eov, input logic [63:0] ed,
                                input logic ep, input logic ee);
        vec_t t;
        t.valid     = v;
        t.din       = d;
        t.rdy       = r;
        t.e_oready  = eor;
        t.e_ovalid  = eov;
        t.e_dout    = ed;
        t.e_pending = ep;
        t.e_empty   = ee;
        return t;
    endfunction

    vec_t tbl [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b, c, d, e, f, g, h, i3, j, k;
        int unsigned  guard;
        int unsigned  in0, out0;

        a  = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        b  = 128'h0009_000A_000B_000C_000D_000E_000F_0010;
        c  = 128'hC1C1_C1C1_C1C1_C1C1_C2C2_C2C2_C2C2_C2C2;
        d  = 128'hD1D1_D1D1_D1D1_D1D1_D2D2_D2D2_D2D2_D2D2;
        e  = 128'hE1E1_E1E1_E1E1_E1E1_E2E2_E2E2_E2E2_E2E2;
        f  = 128'hF1F1_F1F1_F1F1_F1F1_F2F2_F2F2_F2F2_F2F2;
        g  = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
        h  = 128'h3333_3333_3333_3333_4444_4444_4444_4444;
        i3 = 128'h5555_5555_5555_5555_6666_6666_6666_6666;
        j  = 128'h7777_7777_7777_7777_8888_8888_8888_8888;
        k  = 128'h9999_9999_9999_9999_AAAA_AAAA_AAAA_AAAA;

        // single pair
        tbl.push_back(mk(1'b1, a,  1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1));
        tbl.push_back(mk(1'b1, b,  1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 1'b1));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, hi(a),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, lo(a),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, hi(b),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, lo(b),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1));
        // odd beat, with one stalled word
        tbl.push_back(mk(1'b1, c,  1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1));
        tbl.push_back(mk(1'b1, d,  1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 1'b1));
        tbl.push_back(mk(1'b1, e,  1'b1, 1'b1, 1'b1, hi(c),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b1, lo(c),  1'b1, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, lo(c),  1'b1, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, hi(d),  1'b1, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, lo(d),  1'b1, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 1'b1));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 1'b1));
        tbl.push_back(mk(1'b1, f,  1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 1'b1));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, hi(e),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, lo(e),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, hi(f),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, lo(f),  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1));

        // ---------------- initial reset ----------------
        RST    = 1'b1;
        iVALID = 1'b0;
        iREADY = 1'b0;
        DIN    = '0;
        #12;
        chk1("rst_oready",  oREADY,  1'b0);
        chk1("rst_ovalid",  oVALID,  1'b0);
        chk ("rst_dout",    DOUT,    64'h0);
        chk1("rst_full",    FULL,    1'b0);
        chk1("rst_empty",   EMPTY,   1'b1);
        chk1("rst_pending", PENDING, 1'b0);
        step();
        RST = 1'b0;
        #1;
        chk1("rel_oready", oREADY, 1'b1);

        // ---------------- table ----------------
        for (int n = 0; n < tbl.size(); n++) begin
            iVALID = tbl[n].valid;
            DIN    = tbl[n].din;
            iREADY = tbl[n].rdy;
            chk1($sformatf("tbl%0d_oready",  n), oREADY,  tbl[n].e_oready);
            chk1($sformatf("tbl%0d_ovalid",  n), oVALID,  tbl[n].e_ovalid);
            chk ($sformatf("tbl%0d_dout",    n), DOUT,    tbl[n].e_dout);
            chk1($sformatf("tbl%0d_pending", n), PENDING, tbl[n].e_pending);
            chk1($sformatf("tbl%0d_empty",   n), EMPTY,   tbl[n].e_empty);
            step();
        end
        iVALID = 1'b0;

        // ---------------- reset mid-stream (1.5 entries, partly read) ----------------
        iREADY = 1'b0;
        iVALID = 1'b1; DIN = g;  step();
        DIN = h;  step();
        DIN = i3; step();
        iVALID = 1'b0; iREADY = 1'b1; step();
        iREADY = 1'b0;
        chk1("mid_ovalid_pre",  oVALID,  1'b1);
        chk1("mid_pending_pre", PENDING, 1'b1);
        chk ("mid_dout_pre",    DOUT,    lo(g));
        RST = 1'b1;
        #1;
        chk1("mid_rst_ovalid",  oVALID,  1'b0);
        chk1("mid_rst_empty",   EMPTY,   1'b1);
        chk1("mid_rst_pending", PENDING, 1'b0);
        chk1("mid_rst_oready",  oREADY,  1'b0);
        chk ("mid_rst_dout",    DOUT,    64'h0);
        step();
        chk1("mid_rst_oready2", oREADY,  1'b0);
        RST = 1'b0;
        #1;
        chk1("mid_rel_oready",  oREADY,  1'b1);
        chk1("mid_rel_empty",   EMPTY,   1'b1);
        iREADY = 1'b1;
        iVALID = 1'b1; DIN = j; step();
        DIN = k; step();
        iVALID = 1'b0;
        chk("mid_widx_restart", DOUT, hi(j));
        for (int w = 0; w < 4; w++) step();
        chk1("mid_drained_empty", EMPTY, 1'b1);

        // ---------------- full ----------------
        iREADY = 1'b0;
        for (int n = 0; n < 2 * DEPTH; n++) begin
            iVALID = 1'b1;
            DIN    = beat(n);
            chk1($sformatf("fill%0d_oready", n), oREADY, 1'b1);
            step();
        end
        iVALID = 1'b0;
        chk1("full_flag",   FULL,   1'b1);
        chk1("full_oready", oREADY, 1'b0);
        iVALID = 1'b1; DIN = beat(999); step(); step();
        iVALID = 1'b0;
        chk1("full_reject_pending", PENDING, 1'b0);
        chk1("full_reject_full",    FULL,    1'b1);
        iREADY = 1'b1;
        chk("drain_w0", DOUT, hi(beat(0))); chk1("drain_w0_oready", oREADY, 1'b0); step();
        chk("drain_w1", DOUT, lo(beat(0))); chk1("drain_w1_oready", oREADY, 1'b0); step();
        chk("drain_w2", DOUT, hi(beat(1))); chk1("drain_w2_oready", oREADY, 1'b0); step();
        chk("drain_w3", DOUT, lo(beat(1))); chk1("drain_w3_oready", oREADY, 1'b0); step();
        chk1("after_pop_oready", oREADY, 1'b1);
        chk1("after_pop_full",   FULL,   1'b0);

        // ---------------- simultaneous push and pop at DEPTH-1 ----------------
        step(); step();
        iVALID = 1'b1; DIN = beat(100); step();
        DIN = beat(101); step();
        iVALID = 1'b0;
        chk1("pushpop_full",   FULL,   1'b0);
        chk1("pushpop_oready", oREADY, 1'b1);
        chk ("pushpop_dout",   DOUT,   hi(beat(4)));
        guard = 0;
        while (oVALID && guard < 200) begin
            step();
            guard++;
        end
        chk1("full_drain_bound", guard < 200, 1'b1);
        chk1("full_drain_empty", EMPTY, 1'b1);

        // ---------------- back-pressure with continuous streaming ----------------
        in0  = words_in;
        out0 = words_out;
        iVALID = 1'b1;
        for (int n = 0; n < 400; n++) begin
            DIN    = {$urandom, $urandom, $urandom, $urandom};
            iREADY = 1'($urandom_range(0, 1));
            step();
        end
        iVALID = 1'b0;
        iREADY = 1'b1;
        guard = 0;
        while (oVALID && guard < 200) begin
            step();
            guard++;
        end
        chk1("bp_drain_bound", guard < 200, 1'b1);
        chk ("bp_word_count", 64'(words_out - out0), 64'(words_in - in0));
        chk1("bp_empty", EMPTY, 1'b1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_pair_packer.md
# data_pair_packer

Single-clock packer that takes 128-bit beats and groups each two consecutive accepted beats into one 256-bit entry. Each entry is stored in an internal synchronous FIFO and read out as four 64-bit words, most-significant word of the first beat first. It sits between the frame generator's data write port and the downstream 64-bit frame reader. It replaces the pair-then-word-reverse-then-width-convert chain with one clock domain.

## Interface
- DIN_WIDTH, 128: input beat width.
- DOUT_WIDTH, 64: output word width; DIN_WIDTH must equal 2×DOUT_WIDTH.
- DEPTH, 16: FIFO depth in 256-bit entries; must be a power of 2, ≥2.
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- iVALID  in  1  input beat valid.
- oREADY  out  1  block can accept an input beat.
- DIN  in  DIN_WIDTH  input beat.
- oVALID  out  1  DOUT holds a valid word.
- iREADY  in  1  downstream accepts DOUT.
- DOUT  out  DOUT_WIDTH  output word.
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- PENDING  out  1  a first beat is held, waiting for its partner.

## Operation
- **Input accept:** an input beat is accepted when iVALID && oREADY. oREADY = !RST && (count < DEPTH). oREADY depends only on registered state and has no path from iREADY.
- **Pairing:**
  - Phase 0 accept: store DIN in HOLD and set phase to 1.
  - Phase 1 accept: write the entry built from HOLD (A) and DIN (B), then set phase to 0.
  - PENDING = phase.
- **Entry layout (64-bit word index 0..3):** word0 = A[127:64], word1 = A[63:0], word2 = B[127:64], word3 = B[63:0].
- **FIFO storage:** entries are stored at wr_ptr, read at rd_ptr, with an occupancy counter `count`.
- **Read side (first-word-fall-through):**
  - oVALID = (count != 0).
  - DOUT = word[widx] of entry[rd_ptr] when oVALID, else 0.
- **Read transfer:** a transfer happens when oVALID && iREADY. It increments widx. When widx = 3, widx returns to 0, rd_ptr advances and the entry is popped.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Flags:** FULL = (count == DEPTH); EMPTY = (count == 0).
- **Full boundary:** at count == DEPTH, oREADY is low even if a pop occurs in the same cycle. It rises the cycle after.
- **Odd beat:** a held odd beat stays in HOLD indefinitely; there is no flush or padding.
- **Protocol violations:**
  - iVALID while !oREADY: no effect.
  - iREADY while !oVALID: no effect.

## Timing
- **Reset (asynchronous):** while RST is high, all of the following are cleared: phase, HOLD, count, wr_ptr, rd_ptr, widx. Outputs during reset:
  - oREADY = 0, oVALID = 0, DOUT = 0.
  - FULL = 0, EMPTY = 1, PENDING = 0.
  - Memory contents are not reset.
- **After reset release:** oREADY = 1 on the first cycle.
- **Latency:**
  - A second beat accepted at edge N makes oVALID high after edge N (visible cycle N+1).
  - Word0 appears on DOUT in that same cycle.
- **Throughput:**
  - One 64-bit word per cycle while iREADY is held high.
  - Input sustains one beat per cycle until FULL.
- **Reset mid-operation:** the held half beat and all stored entries are discarded. A partially read entry is discarded and widx returns to 0.
- **Widths:**
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - widx is 2 bits.

## Structure
- **Shared package:**
  - Width constants DIN_WIDTH, DOUT_WIDTH.
  - WORDS_PER_ENTRY = 2×DIN_WIDTH/DOUT_WIDTH = 4.
  - The 256-bit entry typedef.
- **Top level:** holds the pairing phase/HOLD logic and word-order assembly.
- **Sub-module wide_sync_fifo:** one natural sub-module. It contains:
  - the 256-bit memory, pointers and count;
  - the FULL/EMPTY flags;
  - FWFT read with a 256-to-64 word selector.

## Test plan
- **Reset:** assert RST mid-stream with 1.5 entries queued. Required: oVALID = 0, EMPTY = 1, PENDING = 0, oREADY = 0 during RST; oREADY = 1 on the cycle after release.
- **Single pair:** send beat A = 0x0001_0002_0003_0004_0005_0006_0007_0008 with its 64-bit halves distinct, then beat B, with iREADY high. Required: oVALID rises the cycle after B is accepted; DOUT sequence is A[127:64], A[63:0], B[127:64], B[63:0] on 4 consecutive cycles; EMPTY returns to 1.
- **Odd beat:** send 3 beats. Required: exactly 4 words are output, then PENDING = 1 and oVALID = 0. A 4th beat then releases 4 more words.
- **Full:** with iREADY = 0, stream 2×DEPTH beats. Required: FULL = 1 and oREADY = 0 after the 2×DEPTH-th beat; further beats are not accepted. Draining 4 words raises oREADY one cycle after the pop.
- **Back-pressure and concurrency:** toggle iREADY randomly while streaming continuously. Required: the output word stream equals the reference order with no loss or duplication. A simultaneous push and pop keeps count constant.
